// File: rtl/id_ex_pipe.sv
// id_ex_pipe: decode->execute pipeline register with one-entry skid buffer.
// Ports: clk, rst (sync, active-high); decode side valid_i/ready_o + payload
//   inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i; flush_i from
//   execute; execute side valid_o/ready_i + registered payload *_o.
// Optional: define ID_EX_STALL_CNT_EN to add stall_cnt_o (saturating count of
//   cycles with valid_o=1 and ready_i=0; cleared only by rst).
module id_ex_pipe #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        reg_wen_i,
    input  logic        flush_i,
    output logic        valid_o,
    input  logic        ready_i,
`ifdef ID_EX_STALL_CNT_EN
    output logic [31:0] stall_cnt_o,
`endif
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic [31:0] op1_o,
    output logic [31:0] op2_o,
    output logic [4:0]  rd_addr_o,
    output logic        reg_wen_o
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        wen;
    } bundle_t;

    localparam bundle_t NOP_B = '{
        inst: NOP_INST, addr: 32'd0, op1: 32'd0,
        op2: 32'd0, rd: 5'd0, wen: 1'b0
    };

    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    logic    main_v_q, main_v_d;
    logic    skid_v_q, skid_v_d;
    bundle_t in_b;
    logic    accept;
    logic    fire;

    assign in_b = '{
        inst: inst_i, addr: inst_addr_i, op1: op1_i,
        op2: op2_i, rd: rd_addr_i, wen: reg_wen_i
    };

    // ready_o comes straight from the skid flop, so ready_i never
    // reaches decode combinationally.
    assign ready_o = ~skid_v_q;
    assign accept  = valid_i & ~skid_v_q;
    assign fire    = main_v_q & ready_i;

    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush_i) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            main_d   = NOP_B;
            skid_d   = NOP_B;
        end else if (!main_v_q) begin
            if (accept) begin
                main_v_d = 1'b1;
                main_d   = in_b;
            end
        end else if (!skid_v_q) begin
            if (fire && accept) begin
                main_d = in_b;
            end else if (fire) begin
                // Drained: present NOP payload, never stale data.
                main_v_d = 1'b0;
                main_d   = NOP_B;
            end else if (accept) begin
                skid_v_d = 1'b1;
                skid_d   = in_b;
            end
        end else if (fire) begin
            // Skid entry is older than anything decode can send next.
            main_d   = skid_q;
            skid_v_d = 1'b0;
            skid_d   = NOP_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q   <= NOP_B;
            skid_q   <= NOP_B;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign valid_o     = main_v_q;
    assign inst_o      = main_q.inst;
    assign inst_addr_o = main_q.addr;
    assign op1_o       = main_q.op1;
    assign op2_o       = main_q.op2;
    assign rd_addr_o   = main_q.rd;
    assign reg_wen_o   = main_q.wen;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_v_q && !ready_i && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed self-checking bench for id_ex_pipe.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_id_ex_pipe;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [4:0]  rd_addr_i;
    logic        reg_wen_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    logic [4:0]  rd_addr_o;
    logic        reg_wen_o;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .inst_i      (inst_i),
        .inst_addr_i (inst_addr_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .rd_addr_i   (rd_addr_i),
        .reg_wen_i   (reg_wen_i),
        .flush_i     (flush_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
`ifdef ID_EX_STALL_CNT_EN
        .stall_cnt_o (stall_cnt_o),
`endif
        .inst_o      (inst_o),
        .inst_addr_o (inst_addr_o),
        .op1_o       (op1_o),
        .op2_o       (op2_o),
        .rd_addr_o   (rd_addr_o),
        .reg_wen_o   (reg_wen_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] ins);
        valid_i     = v;
        inst_addr_i = a;
        inst_i      = ins;
        op1_i       = a + 32'h100;
        op2_i       = a + 32'h200;
        rd_addr_i   = a[6:2] + 5'd1;
        reg_wen_i   = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'h40, 32'h00500293);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (valid_o !== 1'b0 || ready_o !== 1'b1 ||
                inst_o !== NOP || reg_wen_o !== 1'b0 ||
                inst_addr_o !== 32'd0 || op1_o !== 32'd0 ||
                op2_o !== 32'd0 || rd_addr_o !== 5'd0) begin
                failures++;
                $display("FAIL reset[%0d]: v=%b r=%b inst=%h wen=%b addr=%h want v=0 r=1 inst=%h wen=0 addr=0",
                         i, valid_o, ready_o, inst_o, reg_wen_o, inst_addr_o, NOP);
            end
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, NOP);
    endtask

    task automatic test_stream();
        logic [31:0] insts [3];
        insts[0] = 32'h00100093;
        insts[1] = 32'h00200113;
        insts[2] = 32'h00300193;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i * 4), insts[i]);
            step();
            checks++;
            if (valid_o !== 1'b1 || inst_o !== insts[i] ||
                inst_addr_o !== 32'(i * 4) ||
                op1_o !== 32'(i * 4 + 256) ||
                op2_o !== 32'(i * 4 + 512) ||
                rd_addr_o !== 5'(i + 1) || reg_wen_o !== 1'b1) begin
                failures++;
                $display("FAIL stream[%0d]: v=%b inst=%h addr=%h op1=%h rd=%0d want v=1 inst=%h addr=%h",
                         i, valid_o, inst_o, inst_addr_o, op1_o, rd_addr_o,
                         insts[i], i * 4);
            end
        end
        drive(1'b0, 32'h0, NOP);
        step();
        checks++;
        if (valid_o !== 1'b0 || inst_o !== NOP || reg_wen_o !== 1'b0 ||
            inst_addr_o !== 32'd0 || op1_o !== 32'd0) begin
            failures++;
            $display("FAIL stream_idle: v=%b inst=%h wen=%b addr=%h want v=0 inst=%h wen=0 addr=0",
                     valid_o, inst_o, reg_wen_o, inst_addr_o, NOP);
        end
    endtask

    task automatic test_skid();
        ready_i = 1'b0;
        drive(1'b1, 32'h0, 32'h00000093);
        step();
        checks++;
        if (valid_o !== 1'b1 || ready_o !== 1'b1 || inst_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL skid_one: v=%b r=%b addr=%h want v=1 r=1 addr=0",
                     valid_o, ready_o, inst_addr_o);
        end
        drive(1'b1, 32'h4, 32'h00000113);
        step();
        checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b1 || inst_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL skid_full: r=%b v=%b addr=%h want r=0 v=1 addr=0",
                     ready_o, valid_o, inst_addr_o);
        end
        drive(1'b1, 32'h8, 32'h00000193);
        step();
        checks++;
        if (ready_o !== 1'b0 || inst_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL skid_block: r=%b addr=%h want r=0 addr=0",
                     ready_o, inst_addr_o);
        end
        ready_i = 1'b1;
        step();
        checks++;
        if (valid_o !== 1'b1 || ready_o !== 1'b1 || inst_addr_o !== 32'h4 ||
            inst_o !== 32'h00000113) begin
            failures++;
            $display("FAIL skid_drain1: v=%b r=%b addr=%h inst=%h want v=1 r=1 addr=4 inst=00000113",
                     valid_o, ready_o, inst_addr_o, inst_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || inst_addr_o !== 32'h8 ||
            inst_o !== 32'h00000193) begin
            failures++;
            $display("FAIL skid_drain2: v=%b addr=%h inst=%h want v=1 addr=8 inst=00000193",
                     valid_o, inst_addr_o, inst_o);
        end
        drive(1'b0, 32'h0, NOP);
        step();
        checks++;
        if (valid_o !== 1'b0 || inst_o !== NOP) begin
            failures++;
            $display("FAIL skid_empty: v=%b inst=%h want v=0 inst=%h",
                     valid_o, inst_o, NOP);
        end
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        drive(1'b1, 32'h10, 32'h00000213);
        step();
        drive(1'b1, 32'h14, 32'h00000293);
        step();
        checks++;
        if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_setup: r=%b want r=0", ready_o);
        end
        flush_i = 1'b1;
        ready_i = 1'b1;
        drive(1'b1, 32'h18, 32'h00400213);
        step();
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || inst_o !== NOP ||
            inst_addr_o !== 32'd0 || reg_wen_o !== 1'b0) begin
            failures++;
            $display("FAIL flush: v=%b r=%b inst=%h addr=%h wen=%b want v=0 r=1 inst=%h addr=0 wen=0",
                     valid_o, ready_o, inst_o, inst_addr_o, reg_wen_o, NOP);
        end
        flush_i = 1'b0;
        drive(1'b0, 32'h0, NOP);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (valid_o !== 1'b0 || inst_o === 32'h00400213) begin
                failures++;
                $display("FAIL flush_after[%0d]: v=%b inst=%h want v=0 inst!=00400213",
                         i, valid_o, inst_o);
            end
        end
    endtask

    task automatic test_rst_stall();
        ready_i = 1'b0;
        drive(1'b1, 32'h20, 32'h00000313);
        step();
        drive(1'b1, 32'h24, 32'h00000393);
        step();
        drive(1'b0, 32'h0, NOP);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || inst_o !== NOP ||
            inst_addr_o !== 32'd0 || reg_wen_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_stall: v=%b r=%b inst=%h addr=%h wen=%b want v=0 r=1 inst=%h addr=0 wen=0",
                     valid_o, ready_o, inst_o, inst_addr_o, reg_wen_o, NOP);
        end
        ready_i = 1'b1;
        drive(1'b1, 32'h30, 32'h00700393);
        step();
        checks++;
        if (valid_o !== 1'b1 || inst_o !== 32'h00700393 ||
            inst_addr_o !== 32'h30) begin
            failures++;
            $display("FAIL rst_after: v=%b inst=%h addr=%h want v=1 inst=00700393 addr=30",
                     valid_o, inst_o, inst_addr_o);
        end
        drive(1'b0, 32'h0, NOP);
        step();
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_drain: v=%b r=%b want v=0 r=1 (no stale skid entry)",
                     valid_o, ready_o);
        end
    endtask

`ifdef ID_EX_STALL_CNT_EN
    task automatic test_stall_cnt();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (stall_cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL cnt_reset: cnt=%0d want 0", stall_cnt_o);
        end
        ready_i = 1'b0;
        drive(1'b1, 32'h40, 32'h00800413);
        step();
        drive(1'b0, 32'h0, NOP);
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (stall_cnt_o !== 32'd5) begin
            failures++;
            $display("FAIL cnt_stall: cnt=%0d want 5", stall_cnt_o);
        end
        flush_i = 1'b1;
        ready_i = 1'b1;
        step();
        flush_i = 1'b0;
        checks++;
        if (stall_cnt_o !== 32'd5) begin
            failures++;
            $display("FAIL cnt_flush: cnt=%0d want 5", stall_cnt_o);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (stall_cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL cnt_rst: cnt=%0d want 0", stall_cnt_o);
        end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        flush_i = 1'b0;
        ready_i = 1'b0;
        drive(1'b0, 32'h0, NOP);
        #1;
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_rst_stall();
`ifdef ID_EX_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
